// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline (PC, FD, DE, EM, MW).
// Produces stage write enables and bubble strobes, and counts front-end stall cycles.
module pipeline_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic        de_mem_read,
    input  logic [4:0]  de_dst_reg,
    input  logic        de_muldiv_start,
    input  logic        em_take_branch,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        muldiv_busy,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

    // Enable/flush vectors are ordered {pc, fd, de, em, mw} and {fd, de, em}.
    localparam logic [4:0] WREN_ALL  = 5'b11111;
    localparam logic [4:0] WREN_NONE = 5'b00000;
    localparam logic [4:0] WREN_MD   = 5'b00011;
    localparam logic [4:0] WREN_LU   = 5'b00111;

    state_t           state_q, state_n, ret_q, ret_n, eff_state;
    logic [CNT_W-1:0] md_cnt, md_cnt_n;
    logic             freeze, load_use;
    logic [4:0]       wren;
    logic [2:0]       flush;

    // On the ack cycle of a memory wait, lower priorities are judged as if already back in the saved state.
    always_comb begin
        freeze    = ((state_q == RUN) && dmem_req && !dmem_ack)
                  || ((state_q == MEM_WAIT) && !dmem_ack);
        load_use  = de_mem_read && (de_dst_reg != 5'd0)
                  && ((fd_uses_rs && (fd_rs == de_dst_reg))
                   || (fd_uses_rt && (fd_rt == de_dst_reg)));
        eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
    end

    always_comb begin
        state_n  = state_q;
        ret_n    = ret_q;
        md_cnt_n = md_cnt;
        wren     = WREN_ALL;
        flush    = 3'b000;
        if (freeze) begin
            wren = WREN_NONE;
            if (state_q != MEM_WAIT) begin
                state_n = MEM_WAIT;
                ret_n   = state_q;
            end
        end else begin
            state_n = eff_state;
            if (em_take_branch) begin
                flush = 3'b111;
                if (eff_state == MD_BUSY) begin
                    state_n  = RUN;
                    md_cnt_n = '0;
                end
            end else if (eff_state == MD_BUSY) begin
                if (md_cnt != '0) begin
                    wren     = WREN_MD;
                    flush    = 3'b001;
                    md_cnt_n = md_cnt - CNT_W'(1);
                end else begin
                    state_n = RUN;
                end
            end else if (de_muldiv_start) begin
                wren     = WREN_MD;
                flush    = 3'b001;
                md_cnt_n = MD_LOAD;
                state_n  = MD_BUSY;
            end else if (load_use) begin
                wren  = WREN_LU;
                flush = 3'b010;
            end
        end
    end

    assign {pc_wren, fd_wren, de_wren, em_wren, mw_wren} = reset_n ? wren : WREN_NONE;
    assign {fd_flush, de_flush, em_flush}                = reset_n ? flush : 3'b000;
    assign muldiv_busy = (state_q == MD_BUSY);
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RUN;
            ret_q        <= RUN;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_n;
            ret_q   <= ret_n;
            md_cnt  <= md_cnt_n;
            if (!pc_wren) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MD_CYCLES=4): vector table through a
// scoreboard queue, plus a bounded mult/div sequence.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  fd_rs, fd_rt, de_dst_reg;
    logic        fd_uses_rs, fd_uses_rt, de_mem_read, de_muldiv_start;
    logic        em_take_branch, dmem_req, dmem_ack;
    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_flush, de_flush, em_flush, muldiv_busy;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_CYCLES(4), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg), .de_muldiv_start(de_muldiv_start),
        .em_take_branch(em_take_branch), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren), .em_wren(em_wren), .mw_wren(mw_wren),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .muldiv_busy(muldiv_busy), .state(state), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit       rst_n;
        bit [4:0] rs, rt;
        bit       urs, urt, mr;
        bit [4:0] dst;
        bit       md, br, req, ack;
        bit [4:0] wren;
        bit [2:0] flush;
        bit [1:0] st;
    } vec_t;

    typedef struct {
        bit [4:0]  wren;
        bit [2:0]  flush;
        bit [1:0]  st;
        bit [31:0] stall;
    } exp_t;

    localparam bit [4:0] W_ALL = 5'b11111, W_NONE = 5'b00000, W_MD = 5'b00011, W_LU = 5'b00111;
    localparam bit [2:0] F_NO = 3'b000, F_ALL = 3'b111, F_DE = 3'b010, F_EM = 3'b001;

    vec_t      vecs[$];
    exp_t      sb[$];
    bit [31:0] model_stall;
    int        checks = 0;
    int        passes = 0;

    function automatic vec_t mk(bit rst, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt, bit mr,
                                bit [4:0] dst, bit md, bit br, bit req, bit ack,
                                bit [4:0] wren, bit [2:0] flush, bit [1:0] st);
        vec_t v;
        v.rst_n = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
        v.dst = dst; v.md = md; v.br = br; v.req = req; v.ack = ack;
        v.wren = wren; v.flush = flush; v.st = st;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        reset_n = v.rst_n; fd_rs = v.rs; fd_rt = v.rt; fd_uses_rs = v.urs; fd_uses_rt = v.urt;
        de_mem_read = v.mr; de_dst_reg = v.dst; de_muldiv_start = v.md;
        em_take_branch = v.br; dmem_req = v.req; dmem_ack = v.ack;
        e.wren = v.wren; e.flush = v.flush; e.st = v.st; e.stall = model_stall;
        sb.push_back(e);
        if (!v.rst_n) model_stall = 0;
        else if (!v.wren[4]) model_stall++;
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            compare($sformatf("scoreboard_empty_%0d", idx), 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        compare($sformatf("wren_%0d", idx), {27'd0, pc_wren, fd_wren, de_wren, em_wren, mw_wren}, {27'd0, e.wren});
        compare($sformatf("flush_%0d", idx), {29'd0, fd_flush, de_flush, em_flush}, {29'd0, e.flush});
        compare($sformatf("state_%0d", idx), {30'd0, state}, {30'd0, e.st});
        compare($sformatf("busy_%0d", idx), {31'd0, muldiv_busy}, {31'd0, (e.st == 2'd2)});
        compare($sformatf("stall_cycles_%0d", idx), stall_cycles, e.stall);
    endtask

    task automatic step(input vec_t v, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pc_low;
        int budget;
        model_stall = 0;
        //             rst rs  rt  urs urt mr dst md br rq ak  wren    flush  st
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_NONE, F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 5,  0,  1,  0,  1, 5,  0, 0, 0, 0, W_LU,   F_DE,  2'd0));
        vecs.push_back(mk(1, 0,  0,  1,  0,  1, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 3,  7,  1,  1,  1, 7,  0, 0, 0, 0, W_LU,   F_DE,  2'd0));
        vecs.push_back(mk(1, 7,  7,  0,  0,  1, 7,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 1, 0, 0, W_ALL,  F_ALL, 2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 1, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, W_NONE, F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, W_NONE, F_NO,  2'd1));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, W_NONE, F_NO,  2'd1));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 1, W_ALL,  F_NO,  2'd1));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_ALL,  F_NO,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 1, 0, 0, W_ALL,  F_ALL, 2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 9,  0,  1,  0,  1, 9,  0, 1, 1, 0, W_NONE, F_NO,  2'd0));
        vecs.push_back(mk(1, 9,  0,  1,  0,  1, 9,  0, 1, 1, 1, W_ALL,  F_ALL, 2'd1));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_MD,   F_EM,  2'd2));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, W_NONE, F_NO,  2'd2));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, W_NONE, F_NO,  2'd0));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, W_NONE, F_NO,  2'd1));
        vecs.push_back(mk(1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, W_ALL,  F_NO,  2'd0));

        // Initial reset edge so the table starts from a known RUN state.
        reset_n = 1'b0; fd_rs = '0; fd_rt = '0; fd_uses_rs = 0; fd_uses_rt = 0;
        de_mem_read = 0; de_dst_reg = '0; de_muldiv_start = 0;
        em_take_branch = 0; dmem_req = 0; dmem_ack = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // One-cycle mult/div request: the stall must last exactly four cycles.
        reset_n = 1'b1;
        de_muldiv_start = 1'b1;
        pc_low = 0;
        budget = 0;
        @(negedge clk);
        if (!pc_wren) pc_low++;
        @(posedge clk);
        #1;
        de_muldiv_start = 1'b0;
        while (state != 2'd0 && budget < 20) begin
            @(negedge clk);
            if (!pc_wren) pc_low++;
            @(posedge clk);
            #1;
            budget++;
        end
        compare("md_wait_timeout", {31'd0, (budget >= 20)}, 32'd0);
        compare("md_stall_len", pc_low, 32'd4);
        @(negedge clk);
        compare("md_stall_cycles", stall_cycles, model_stall + 32'd4);
        compare("md_after_wren", {27'd0, pc_wren, fd_wren, de_wren, em_wren, mw_wren}, {27'd0, W_ALL});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
